seg7_scan_driver: RTL and testbench

- Time-multiplexed driver for the board's 8-digit common-cathode 7-segment display (`seg`/`dig` pins of the count-game top level).
- Sits directly downstream of the game core: the core presents eight hex nibbles plus per-digit dp/blank/blink masks and strobes `upd`.
- The driver double-buffers the data, scans one digit per slot, applies frame-aligned updates (no tearing) and blinking.

---
 rtl/seg7_scan_driver.sv | 156 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-cathode 7-segment display.
// Double-buffers digit data, scans one digit per slot, and applies updates and blinking on frame boundaries.
module seg7_scan_driver #(
  parameter int CLK_DIV      = 1000,
  parameter int BLANK_CYC    = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        upd,
  input  logic [31:0] digits,
  input  logic [7:0]  dp,
  input  logic [7:0]  blank,
  input  logic [7:0]  blink,
  output logic [7:0]  seg,
  output logic [7:0]  dig,
  output logic        frame_tick
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] BLANK_LIM  = PW'(BLANK_CYC);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  typedef struct packed {
    logic [31:0] digits;
    logic [7:0]  dp;
    logic [7:0]  blank;
    logic [7:0]  blink;
  } disp_t;

  localparam disp_t SHADOW_RST = '{digits: 32'h0, dp: 8'h00, blank: 8'hFF, blink: 8'h00};

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;
  logic          slot_end;
  logic          frame_end;

  disp_t         in_data;
  disp_t         pend;
  logic          pend_vld;
  disp_t         shadow;

  logic [3:0]    cur_nib;
  logic          cur_off;
  logic [7:0]    seg_n;
  logic [7:0]    dig_n;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign slot_end  = (presc == PRESC_LAST);
  assign frame_end = slot_end && (idx == 3'd7);
  assign in_data   = '{digits: digits, dp: dp, blank: blank, blink: blink};

  // Scan timing: prescaler, digit index, frame counter and blink phase.
  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc       <= '0;
      idx         <= 3'd0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (slot_end) begin
        presc <= '0;
        idx   <= idx + 3'd1;
      end else begin
        presc <= presc + 1'b1;
      end
      if (frame_end) begin
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  // Pending/shadow double buffer; shadow only moves on the frame boundary edge,
  // and an update landing exactly on that edge bypasses the pending stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= '0;
      pend_vld <= 1'b0;
      // NOTE: shadow resets with every digit blanked so nothing lights before the first update.
      shadow   <= SHADOW_RST;
    end else begin
      if (frame_end) begin
        if (upd) begin
          shadow <= in_data;
        end else if (pend_vld) begin
          shadow <= pend;
        end
        pend_vld <= 1'b0;
      end else if (upd) begin
        pend     <= in_data;
        pend_vld <= 1'b1;
      end
    end
  end

  // Next segment/digit pattern from the current slot position.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    seg_n   = 8'h00;
    dig_n   = 8'hFF;
    cur_nib = shadow.digits[{idx, 2'b00} +: 4];
    cur_off = shadow.blank[idx] | (blink_phase & shadow.blink[idx]);
    if (presc >= BLANK_LIM) begin
      dig_n = ~(8'b1 << idx);
      if (!cur_off) begin
        seg_n = {shadow.dp[idx], hex7(cur_nib)};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= 8'h00;
      dig <= 8'hFF;
    end else begin
      seg <= seg_n;
      dig <= dig_n;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a frame-level reference model predicts every output cycle,
// and a negedge monitor compares the DUT against the queued predictions.
module tb_seg7_scan_driver;

  localparam int CD = 4;
  localparam int BC = 1;
  localparam int BF = 2;
  localparam int FRAME = 8 * CD;

  logic        clk = 1'b0;
  logic        rst;
  logic        upd;
  logic [31:0] digits;
  logic [7:0]  dp;
  logic [7:0]  blank;
  logic [7:0]  blink;
  logic [7:0]  seg;
  logic [7:0]  dig;
  logic        frame_tick;

  typedef struct {
    int          eff;
    logic [31:0] d;
    logic [7:0]  p;
    logic [7:0]  b;
    logic [7:0]  k;
  } upd_t;

  upd_t        upd_log[$];
  logic [16:0] exp_q[$];
  int          cyc;
  logic        run;
  int          checks = 0;
  int          errors = 0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_scan_driver #(.CLK_DIV(CD), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut (
    .clk        (clk),
    .rst        (rst),
    .upd        (upd),
    .digits     (digits),
    .dp         (dp),
    .blank      (blank),
    .blink      (blink),
    .seg        (seg),
    .dig        (dig),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected {seg, dig, frame_tick} for the t-th output cycle after reset release.
  function automatic logic [16:0] model(input int t);
    int          slot;
    int          pos;
    int          fr;
    logic        ft;
    logic        phase;
    logic [31:0] d;
    logic [7:0]  p;
    logic [7:0]  b;
    logic [7:0]  k;
    logic [7:0]  s;
    logic [7:0]  g;
    logic [3:0]  nib;
    slot  = (t / CD) % 8;
    pos   = t % CD;
    fr    = t / FRAME;
    ft    = ((t % FRAME) == FRAME - 1);
    phase = ((fr / BF) % 2) == 1;
    d = 32'h0; p = 8'h00; b = 8'hFF; k = 8'h00;
    foreach (upd_log[i]) begin
      if (upd_log[i].eff <= fr) begin
        d = upd_log[i].d; p = upd_log[i].p; b = upd_log[i].b; k = upd_log[i].k;
      end
    end
    s = 8'h00;
    g = 8'hFF;
    if (pos >= BC) begin
      g[slot] = 1'b0;
      nib = d[slot*4 +: 4];
      if (!(b[slot] || (phase && k[slot]))) s = {p[slot], hex_tab[nib]};
    end
    return {s, g, ft};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      cyc <= 0;
    end else if (run) begin
      exp_q.push_back(model(cyc));
      cyc <= cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [16:0] e;
      e = exp_q.pop_front();
      check("scan", {15'h0, seg, dig, frame_tick}, {15'h0, e});
    end
  end

  task automatic wait_until(input int k);
    int guard;
    guard = 0;
    while (cyc < k && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20000) check("wait_timeout", 32'(cyc), 32'(k));
  endtask

  // Called at a negedge; the upcoming edge index is cyc, so the data shows from the next frame.
  task automatic do_upd(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b,
                        input logic [7:0] k);
    upd = 1'b1; digits = d; dp = p; blank = b; blink = k;
    upd_log.push_back('{cyc / FRAME + 1, d, p, b, k});
    @(negedge clk);
    upd = 1'b0;
    digits = $urandom; dp = 8'($urandom); blank = 8'($urandom); blink = 8'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; run = 1'b0; upd = 1'b0;
    digits = '0; dp = '0; blank = '0; blink = '0;
    repeat (2) @(negedge clk);
    check("reset_seg", {24'h0, seg}, 32'h00);
    check("reset_dig", {24'h0, dig}, 32'hFF);
    rst = 1'b0; run = 1'b1;

    // Light the display, leave an update pending, then reset mid-slot 5 of frame 1.
    wait_until(3);
    do_upd(32'h76543210, 8'h00, 8'h00, 8'h00);
    wait_until(40);
    do_upd(32'hFFFFFFFF, 8'hFF, 8'h00, 8'h00);
    wait_until(53);
    run = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_seg", {24'h0, seg}, 32'h00);
    check("async_rst_dig", {24'h0, dig}, 32'hFF);
    check("async_rst_tick", {31'h0, frame_tick}, 32'h0);
    upd_log.delete();
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0; run = 1'b1;

    // Basic scan, then tear-free double update, then an update on the boundary edge.
    wait_until(3);
    do_upd(32'h76543210, 8'h00, 8'h00, 8'h00);
    wait_until(2 * FRAME + 13);
    do_upd(32'hFFFFFFFF, 8'h00, 8'h00, 8'h00);
    wait_until(2 * FRAME + 21);
    do_upd(32'h88888888, 8'h00, 8'h00, 8'h00);
    wait_until(4 * FRAME - 1);
    do_upd(32'h0000000A, 8'h00, 8'h00, 8'h00);

    // Blink, decimal point and blank masks over several blink periods.
    wait_until(5 * FRAME + 10);
    do_upd(32'h00000011, 8'h02, 8'h80, 8'h01);

    // Walk A..F through digit 2, one frame each.
    wait_until(14 * FRAME + 5);
    for (int v = 10; v < 16; v++) begin
      do_upd(32'(v) << 8, 8'h00, 8'h00, 8'h00);
      wait_until((cyc / FRAME + 1) * FRAME + 5);
    end

    // Random updates, some forced onto the boundary edge.
    for (int i = 0; i < 40; i++) begin
      if (i % 5 == 0) wait_until((cyc / FRAME) * FRAME + FRAME - 1);
      else wait_until(cyc + int'($urandom_range(1, 50)));
      do_upd($urandom, 8'($urandom), 8'($urandom) & 8'h33, 8'($urandom));
    end

    wait_until(cyc + 3 * FRAME);
    run = 1'b0;
    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
